uart_alu_interface: RTL and testbench
=====================================

Name: uart_alu_interface

Overview:
Control stage between the UART receiver/transmitter and the combinational ALU. Collects three received bytes (operand A, operand B, opcode) and holds them on registers that drive the ALU inputs. Captures the ALU result and overflow, then returns two bytes through the UART transmitter: the result, then a status byte. Includes an inter-byte timeout so that a partial frame cannot lock the block.

Parameters:
NB_DATA, 8, UART byte width and ALU operand/result width
NB_OP, 6, ALU opcode width; the opcode is taken from received byte bits [NB_OP-1:0]
TIMEOUT_CYC, 1000000, idle clock cycles allowed between frame bytes before the partial frame is discarded

Ports:
i_clk  in  1  system clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_rx_data  in  NB_DATA  byte from UART RX, valid when i_rx_done=1
i_rx_done  in  1  one-cycle pulse: new byte available
i_alu_result  in  NB_DATA  combinational ALU result
i_alu_overflow  in  1  combinational ALU overflow
i_tx_done  in  1  one-cycle pulse: UART TX finished the current byte
o_dataA  out  NB_DATA  registered operand A to ALU
o_dataB  out  NB_DATA  registered operand B to ALU
o_op  out  NB_OP  registered opcode to ALU
o_tx_data  out  NB_DATA  byte to UART TX, held stable until i_tx_done
o_tx_start  out  1  one-cycle pulse: start transmitting o_tx_data
o_busy  out  1  high in every state except WAIT_A
o_timeout  out  1  one-cycle pulse: partial frame discarded

Behaviour:
- Reset (asynchronous, i_rst_n=0): state=WAIT_A; o_dataA, o_dataB, o_op, o_tx_data all 0; o_tx_start, o_busy, o_timeout all 0; timeout counter 0. Reset asserted mid-frame or mid-transmission aborts immediately. No byte is resumed after reset.
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND_RES, WAIT_RES, SEND_STAT, WAIT_STAT.
- WAIT_A: on i_rx_done, o_dataA<=i_rx_data, then go to WAIT_B.
- WAIT_B: on i_rx_done, o_dataB<=i_rx_data, then go to WAIT_OP.
- WAIT_OP: on i_rx_done, o_op<=i_rx_data[NB_OP-1:0], then go to EXEC.
- EXEC (1 cycle, ALU inputs now stable): capture i_alu_result into a result register; capture the status byte; go to SEND_RES.
- Status byte: bit0=i_alu_overflow; bit1=opcode invalid (not in the package opcode list); all other bits 0.
- SEND_RES (1 cycle): o_tx_data=result, o_tx_start=1, then go to WAIT_RES.
- WAIT_RES: on i_tx_done, go to SEND_STAT.
- SEND_STAT (1 cycle): o_tx_data=status, o_tx_start=1, then go to WAIT_STAT.
- WAIT_STAT: on i_tx_done, go to WAIT_A.
- Latency: opcode i_rx_done at edge N; o_op valid after N; EXEC during cycle N+1; o_tx_start high during cycle N+2.
- Timeout: in WAIT_B and WAIT_OP, the counter increments each cycle and clears on i_rx_done. When the count reaches TIMEOUT_CYC-1: go to WAIT_A, pulse o_timeout for 1 cycle, leave o_dataA/o_dataB/o_op unchanged. The counter is held at 0 in all other states. A timeout and i_rx_done in the same cycle: i_rx_done wins.
- i_rx_done in EXEC or in any SEND/WAIT_RES/WAIT_STAT state is ignored; the byte is dropped.
- i_tx_done outside WAIT_RES and WAIT_STAT is ignored.
- o_tx_start is never high for two consecutive cycles.
- No arithmetic is performed in this block; the ALU result is passed through unchanged.

Decomposition:
- Shared package: opcode localparams (ADD=6'b100000, SUB=6'b100010, AND=6'b100100, OR=6'b100101, XOR=6'b100110, NOR=6'b100111, SRA=6'b000011, SRL=6'b000010); state encodings; status bit indices.
- The ALU opcode decoder must import the same package.
- One sub-module: uart_alu_timeout, a loadable/clearable counter producing the expiry pulse.

Test Plan:
- Frame 0x05, 0x03, 0x20 (ADD) -> o_dataA=0x05, o_dataB=0x03, o_op=0x20; TX bytes 0x08 then 0x00; o_tx_start exactly 2 cycles after the opcode i_rx_done.
- Frame 0x7F, 0x01, 0x20 -> TX 0x80, 0x01. Frame 0x80, 0x01, 0x22 (SUB) -> TX 0x7F, 0x01.
- Frame 0xAA, 0x0F, 0x3F (invalid opcode) -> TX 0xFF, 0x02.
- Send 0x05, 0x03, then silence for TIMEOUT_CYC cycles (bench uses 16) -> o_timeout pulses once; next frame 0x0C, 0x0A, 0x24 (AND) -> TX 0x08, 0x00.
- i_rx_done=0x55 while in WAIT_RES -> byte dropped; o_dataA stays unchanged; after the status byte the block is back in WAIT_A with o_busy=0.
- Assert i_rst_n=0 during WAIT_RES -> all outputs 0 asynchronously (before the next edge); a fresh frame after release completes normally.

Source files
------------

// File: rtl/uart_alu_interface_pkg.sv
// Shared definitions for the UART <-> ALU control slice.
// Contents: ALU opcode values, FSM state encoding, status byte bit
// positions and the opcode validity decoder used to flag unknown opcodes.
package uart_alu_interface_pkg;

    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
    localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
    localparam logic [OP_W-1:0] OP_AND = 6'b100100;
    localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
    localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
    localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
    localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
    localparam logic [OP_W-1:0] OP_SRL = 6'b000010;

    // Bit positions inside the status byte returned after the result byte.
    localparam int STAT_OVF_BIT = 0;
    localparam int STAT_INV_BIT = 1;

    typedef enum logic [2:0] {
        ST_WAIT_A,
        ST_WAIT_B,
        ST_WAIT_OP,
        ST_EXEC,
        ST_SEND_RES,
        ST_WAIT_RES,
        ST_SEND_STAT,
        ST_WAIT_STAT
    } state_t;

    // True when the opcode is one the ALU actually implements.
    function automatic logic op_is_valid(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_alu_interface_timeout.sv
// Inter-byte idle counter for the UART <-> ALU control slice.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   enable     : count while high; counter is held at 0 while low
//   clear      : restart the idle interval (a byte arrived)
//   expired    : high in the cycle the count sits on TIMEOUT_CYC-1
module uart_alu_timeout #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] count;

    // Wrapping back to 0 on expiry keeps the counter bounded even if the
    // owner stays enabled for one more cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!enable || clear || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // A byte arriving in the expiry cycle suppresses the expiry.
    assign expired = enable && !clear && (count == LAST);

endmodule

// File: rtl/uart_alu_interface.sv
// Control stage between UART RX/TX and a combinational ALU.
// Collects operand A, operand B and opcode bytes, holds them on the ALU
// inputs, then sends back the ALU result byte followed by a status byte
// (bit0 overflow, bit1 invalid opcode). A partial frame that goes idle
// for TIMEOUT_CYC cycles is discarded with a one-cycle o_timeout pulse.
// Ports:
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_rx_data/i_rx_done : received byte and its one-cycle strobe
//   i_alu_result/i_alu_overflow : combinational ALU outputs
//   i_tx_done           : UART TX finished the current byte
//   o_dataA/o_dataB/o_op: registered ALU inputs
//   o_tx_data/o_tx_start: byte to send and its one-cycle start strobe
//   o_busy              : high whenever a frame is in progress
//   o_timeout           : one-cycle pulse when a partial frame is dropped
module uart_alu_interface
    import uart_alu_interface_pkg::*;
#(
    parameter int NB_DATA     = 8,
    parameter int NB_OP       = 6,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_alu_overflow,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_dataA,
    output logic [NB_DATA-1:0] o_dataB,
    output logic [NB_OP-1:0]   o_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_timeout
);

    state_t             state;
    logic [NB_DATA-1:0] status_reg;
    logic [NB_DATA-1:0] status_next;
    logic               count_en;
    logic               timeout_hit;

    // The idle timer only runs while a frame is partially received.
    assign count_en = (state == ST_WAIT_B) || (state == ST_WAIT_OP);

    uart_alu_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .enable (count_en),
        .clear  (i_rx_done),
        .expired(timeout_hit)
    );

    // Status byte assembled from the ALU flag and the opcode decoder.
    always_comb begin
        status_next               = '0;
        status_next[STAT_OVF_BIT] = i_alu_overflow;
        status_next[STAT_INV_BIT] = ~op_is_valid(o_op);
    end

    assign o_busy = (state != ST_WAIT_A);

    // Frame sequencer. o_tx_data doubles as the result register: it is
    // loaded in EXEC and held until the TX reports the byte done.
    // o_tx_start is set only on entry to a SEND state, so it can never
    // stay high for two cycles in a row.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_WAIT_A;
            o_dataA    <= '0;
            o_dataB    <= '0;
            o_op       <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_timeout  <= 1'b0;
            status_reg <= '0;
        end else begin
            o_tx_start <= 1'b0;
            o_timeout  <= 1'b0;
            case (state)
                ST_WAIT_A: begin
                    if (i_rx_done) begin
                        o_dataA <= i_rx_data;
                        state   <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (i_rx_done) begin
                        o_dataB <= i_rx_data;
                        state   <= ST_WAIT_OP;
                    end else if (timeout_hit) begin
                        o_timeout <= 1'b1;
                        state     <= ST_WAIT_A;
                    end
                end
                ST_WAIT_OP: begin
                    if (i_rx_done) begin
                        o_op  <= i_rx_data[NB_OP-1:0];
                        state <= ST_EXEC;
                    end else if (timeout_hit) begin
                        o_timeout <= 1'b1;
                        state     <= ST_WAIT_A;
                    end
                end
                ST_EXEC: begin
                    o_tx_data  <= i_alu_result;
                    status_reg <= status_next;
                    o_tx_start <= 1'b1;
                    state      <= ST_SEND_RES;
                end
                ST_SEND_RES: begin
                    state <= ST_WAIT_RES;
                end
                ST_WAIT_RES: begin
                    if (i_tx_done) begin
                        o_tx_data  <= status_reg;
                        o_tx_start <= 1'b1;
                        state      <= ST_SEND_STAT;
                    end
                end
                ST_SEND_STAT: begin
                    state <= ST_WAIT_STAT;
                end
                ST_WAIT_STAT: begin
                    if (i_tx_done) begin
                        state <= ST_WAIT_A;
                    end
                end
                default: begin
                    state <= ST_WAIT_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_interface.sv
// Self-checking bench for uart_alu_interface: directed frames, timeout,
// dropped-byte and mid-frame reset cases, then random frames checked
// against an arithmetic model of the ALU round trip.
module tb_uart_alu_interface;

    logic       i_clk;
    logic       i_rst_n;
    logic [7:0] i_rx_data;
    logic       i_rx_done;
    logic [7:0] i_alu_result;
    logic       i_alu_overflow;
    logic       i_tx_done;
    logic [7:0] o_dataA;
    logic [7:0] o_dataB;
    logic [5:0] o_op;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_busy;
    logic       o_timeout;

    int checks = 0;
    int errors = 0;

    uart_alu_interface #(
        .NB_DATA(8),
        .NB_OP(6),
        .TIMEOUT_CYC(16)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_rx_data     (i_rx_data),
        .i_rx_done     (i_rx_done),
        .i_alu_result  (i_alu_result),
        .i_alu_overflow(i_alu_overflow),
        .i_tx_done     (i_tx_done),
        .o_dataA       (o_dataA),
        .o_dataB       (o_dataB),
        .o_op          (o_op),
        .o_tx_data     (o_tx_data),
        .o_tx_start    (o_tx_start),
        .o_busy        (o_busy),
        .o_timeout     (o_timeout)
    );

    // Free-running clock, 10 time units per period.
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Behavioural ALU: returns {overflow, result} using plain integer math.
    function automatic logic [8:0] alu_model(input logic [7:0] a,
                                             input logic [7:0] b,
                                             input logic [5:0] op);
        int         sum;
        logic [7:0] r;
        logic       v;
        r   = 8'hFF;
        v   = 1'b0;
        sum = 0;
        case (op)
            6'h20: begin
                sum = int'($signed(a)) + int'($signed(b));
                r   = a + b;
                v   = (sum > 127) || (sum < -128);
            end
            6'h22: begin
                sum = int'($signed(a)) - int'($signed(b));
                r   = a - b;
                v   = (sum > 127) || (sum < -128);
            end
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h26: r = a ^ b;
            6'h27: r = ~(a | b);
            6'h03: r = $signed(a) >>> b;
            6'h02: r = a >> b;
            default: r = 8'hFF;
        endcase
        return {v, r};
    endfunction

    // Opcode list the block is expected to accept.
    function automatic logic op_known(input logic [5:0] op);
        logic [5:0] known [8];
        known = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
        foreach (known[i]) if (known[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // The ALU sits outside the DUT and is driven by its held operands.
    always_comb begin
        {i_alu_overflow, i_alu_result} = alu_model(o_dataA, o_dataB, o_op);
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One received byte: strobe i_rx_done across a single active edge.
    task automatic applyStimulus(input logic [7:0] data);
        i_rx_data = data;
        i_rx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
    endtask

    task automatic pulseTxDone();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
    endtask

    // Full frame round trip with expected bytes derived from the model.
    task automatic runFrame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] op_byte, input bit inject,
                            input int d1, input int d2);
        logic [8:0] alu;
        logic [7:0] exp_res;
        logic [7:0] exp_stat;
        alu      = alu_model(a, b, op_byte[5:0]);
        exp_res  = alu[7:0];
        exp_stat = {6'b0, ~op_known(op_byte[5:0]), alu[8]};

        applyStimulus(a);
        checkOutput("dataA", 16'(o_dataA), 16'(a));
        checkOutput("busy_after_A", 16'(o_busy), 16'd1);
        applyStimulus(b);
        checkOutput("dataB", 16'(o_dataB), 16'(b));
        applyStimulus(op_byte);
        checkOutput("op", 16'(o_op), 16'(op_byte[5:0]));
        checkOutput("start_low_in_exec", 16'(o_tx_start), 16'd0);
        tick();
        checkOutput("start_res", 16'(o_tx_start), 16'd1);
        checkOutput("tx_result", 16'(o_tx_data), 16'(exp_res));
        tick();
        checkOutput("start_single_cycle", 16'(o_tx_start), 16'd0);
        if (inject) begin
            applyStimulus(8'h55);
            checkOutput("dropped_byte_dataA", 16'(o_dataA), 16'(a));
        end
        repeat (d1) tick();
        checkOutput("tx_result_held", 16'(o_tx_data), 16'(exp_res));
        pulseTxDone();
        checkOutput("start_stat", 16'(o_tx_start), 16'd1);
        checkOutput("tx_status", 16'(o_tx_data), 16'(exp_stat));
        tick();
        checkOutput("start_stat_single", 16'(o_tx_start), 16'd0);
        repeat (d2) tick();
        checkOutput("busy_before_last_done", 16'(o_busy), 16'd1);
        pulseTxDone();
        checkOutput("idle_after_frame", 16'(o_busy), 16'd0);
    endtask

    initial begin
        logic [5:0] op6;
        i_rst_n   = 1'b0;
        i_rx_data = 8'h00;
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;

        // Reset state.
        #12;
        checkOutput("rst_dataA", 16'(o_dataA), 16'd0);
        checkOutput("rst_tx_start", 16'(o_tx_start), 16'd0);
        checkOutput("rst_busy", 16'(o_busy), 16'd0);
        checkOutput("rst_timeout", 16'(o_timeout), 16'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();

        // Directed frames.
        runFrame(8'h05, 8'h03, 8'h20, 1'b0, 2, 1);
        runFrame(8'h7F, 8'h01, 8'h20, 1'b0, 0, 0);
        runFrame(8'h80, 8'h01, 8'h22, 1'b0, 3, 2);
        runFrame(8'hAA, 8'h0F, 8'h3F, 1'b0, 1, 0);

        // Partial frame goes idle: exactly one timeout pulse, 16 cycles on.
        applyStimulus(8'h05);
        applyStimulus(8'h03);
        for (int k = 1; k <= 20; k++) begin
            tick();
            checkOutput($sformatf("timeout_cyc%0d", k), 16'(o_timeout),
                        (k == 16) ? 16'd1 : 16'd0);
        end
        checkOutput("timeout_idle", 16'(o_busy), 16'd0);
        checkOutput("timeout_keeps_A", 16'(o_dataA), 16'h05);
        checkOutput("timeout_keeps_B", 16'(o_dataB), 16'h03);
        runFrame(8'h0C, 8'h0A, 8'h24, 1'b0, 1, 1);

        // Byte arriving while waiting on TX is dropped.
        runFrame(8'h21, 8'h42, 8'h25, 1'b1, 1, 1);

        // Reset in WAIT_RES clears everything before the next edge.
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h26);
        tick();
        tick();
        #2;
        i_rst_n = 1'b0;
        #1;
        checkOutput("arst_dataA", 16'(o_dataA), 16'd0);
        checkOutput("arst_dataB", 16'(o_dataB), 16'd0);
        checkOutput("arst_op", 16'(o_op), 16'd0);
        checkOutput("arst_tx_data", 16'(o_tx_data), 16'd0);
        checkOutput("arst_busy", 16'(o_busy), 16'd0);
        checkOutput("arst_tx_start", 16'(o_tx_start), 16'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
        runFrame(8'h09, 8'h02, 8'h02, 1'b0, 0, 1);

        // Random frames, including unknown opcodes and junk upper op bits.
        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 9) < 8) begin
                case ($urandom_range(0, 7))
                    0: op6 = 6'h20;
                    1: op6 = 6'h22;
                    2: op6 = 6'h24;
                    3: op6 = 6'h25;
                    4: op6 = 6'h26;
                    5: op6 = 6'h27;
                    6: op6 = 6'h03;
                    default: op6 = 6'h02;
                endcase
            end else begin
                op6 = 6'($urandom);
            end
            runFrame(8'($urandom), 8'($urandom), {2'($urandom), op6},
                     1'($urandom), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
